siren_output_driver: RTL
========================

// Module: siren_output_driver
// PURPOSE
//  Downstream output stage of the anti-theft alarm. Consumes the FSM's siren and
//  statusIndicator levels and drives the physical outputs:
//  - a two-tone warbling square wave for the piezo speaker;
//  - a registered status LED;
//  - a siren lamp.
//  Enforces a maximum continuous siren duration. After that the speaker is muted
//  until siren is released and re-asserted.
// PARAMETERS
//  SEC_COUNT     100000000  clock cycles per second (1 s tick period)
//  MAX_SIREN_S   30         max seconds of continuous sounding before mute, >=1
//  TONE_HI_HALF  25000      half-period in cycles of the high tone (2 kHz @100 MHz)
//  TONE_LO_HALF  41667      half-period in cycles of the low tone (~1.2 kHz)
//  WARBLE_COUNT  25000000   cycles spent in each tone before switching (0.25 s)
// PORTS
//  clock            in   1  system clock, all logic on posedge
//  systemReset      in   1  asynchronous, active-high reset
//  siren            in   1  siren request level from the alarm FSM
//  statusIndicator  in   1  status LED level from the alarm FSM
//  speaker          out  1  square-wave drive to the piezo speaker
//  statusLed        out  1  registered copy of statusIndicator
//  sirenLamp        out  1  high while in SOUNDING or MUTED
//  sirenActive      out  1  high only while in SOUNDING
//  timedOut         out  1  high only while in MUTED
// BEHAVIOUR
//  Reset
//  - systemReset=1 asynchronously forces state IDLE, all counters 0 and every
//    output 0. This applies mid-operation too; there is no partial hold.
//  Status LED
//  - statusLed <= statusIndicator every cycle: 1-cycle latency, no filtering.
//  FSM states
//  - IDLE, SOUNDING, MUTED. Inputs are sampled on posedge; no edge detection
//    beyond state.
//  IDLE
//  - siren=1 -> SOUNDING on the next edge.
//  - On entry to SOUNDING: secCnt=0, tickCnt=0, warbleCnt=0, toneCnt=0,
//    tone=HI, speaker=0.
//  SOUNDING
//  - siren=0 -> IDLE. speaker=0 from that edge on.
//  - Otherwise:
//    - tickCnt counts 0..SEC_COUNT-1. When it wraps, secCnt increments.
//    - When secCnt reaches MAX_SIREN_S (MAX_SIREN_S*SEC_COUNT cycles after
//      entry) -> MUTED.
//  - Simultaneous siren=0 and timeout: siren=0 wins and the state goes to IDLE.
//  Tone generation (SOUNDING only)
//  - toneCnt counts 0..HALF-1, where HALF is TONE_HI_HALF or TONE_LO_HALF for
//    the current tone. At HALF-1, speaker toggles and toneCnt returns to 0.
//  - warbleCnt counts 0..WARBLE_COUNT-1. At WARBLE_COUNT-1, the tone flips
//    HI<->LO and toneCnt returns to 0; speaker keeps its current level.
//  - If a tone flip and a toggle fall on the same cycle, both happen.
//  MUTED
//  - speaker=0, timedOut=1, sirenLamp=1.
//  - Stays while siren=1. siren=0 -> IDLE.
//  - Re-asserting siren restarts a full MAX_SIREN_S window.
//  Outputs
//  - sirenActive, sirenLamp and timedOut are registered decodes of the next
//    state. They change on the same edge as the state.
//  Widths
//  - Each counter uses $clog2 of its terminal value + 1.
//  - No counter may overflow. All wraps are explicit compares to the terminal
//    value.
// TESTING
//  Bench parameters: SEC_COUNT=10, MAX_SIREN_S=3, TONE_HI_HALF=2,
//  TONE_LO_HALF=3, WARBLE_COUNT=12.
//  1 Reset: hold systemReset, wiggle siren/statusIndicator -> all outputs 0.
//    Release -> still 0, state IDLE.
//  2 siren 0->1 -> sirenActive=1 one edge later. speaker toggles every 2 cycles
//    for 12 cycles, then every 3 cycles.
//  3 siren held high -> MUTED exactly 30 cycles after entering SOUNDING.
//    timedOut=1, speaker=0 from then on. Drop siren -> IDLE, all siren outputs 0.
//  4 siren drops after 7 cycles of SOUNDING -> IDLE next edge, speaker=0.
//    Re-raise -> full 30-cycle window, tone restarts HI.
//  5 siren drops on the timeout cycle (cycle 30) -> IDLE, never MUTED;
//    timedOut stays 0.
//  6 Assert systemReset asynchronously mid-SOUNDING with speaker=1 -> speaker,
//    sirenActive, sirenLamp and statusLed go 0 immediately, without waiting
//    for a clock edge.

Source files
------------

// File: rtl/siren_output_driver_if.sv
// Signal bundle between the alarm FSM and the siren output stage.
// The FSM side (master) drives the request levels; the driver side (slave)
// returns the physical output levels.
interface siren_output_driver_if;
  logic siren;
  logic statusIndicator;
  logic speaker;
  logic statusLed;
  logic sirenLamp;
  logic sirenActive;
  logic timedOut;

  modport master (
    output siren,
    output statusIndicator,
    input  speaker,
    input  statusLed,
    input  sirenLamp,
    input  sirenActive,
    input  timedOut
  );

  modport slave (
    input  siren,
    input  statusIndicator,
    output speaker,
    output statusLed,
    output sirenLamp,
    output sirenActive,
    output timedOut
  );
endinterface

// File: rtl/siren_output_driver.sv
// Output stage of the anti-theft alarm: two-tone warbling speaker drive,
// registered status LED, siren lamp, and a cap on continuous sounding time
// after which the speaker is muted until siren is released and re-asserted.
module siren_output_driver #(
  parameter int unsigned SEC_COUNT    = 100000000,
  parameter int unsigned MAX_SIREN_S  = 30,
  parameter int unsigned TONE_HI_HALF = 25000,
  parameter int unsigned TONE_LO_HALF = 41667,
  parameter int unsigned WARBLE_COUNT = 25000000
) (
  input  logic                   clock,
  input  logic                   systemReset,
  siren_output_driver_if.slave   bus
);

  localparam int unsigned TONE_MAX = (TONE_HI_HALF > TONE_LO_HALF) ? TONE_HI_HALF : TONE_LO_HALF;
  localparam int unsigned TICK_W   = $clog2(SEC_COUNT) + 1;
  localparam int unsigned SEC_W    = $clog2(MAX_SIREN_S) + 1;
  localparam int unsigned TONE_W   = $clog2(TONE_MAX) + 1;
  localparam int unsigned WARB_W   = $clog2(WARBLE_COUNT) + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SEC_COUNT - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(MAX_SIREN_S - 1);
  localparam logic [SEC_W-1:0]  SEC_ONE   = SEC_W'(1);
  localparam logic [TONE_W-1:0] HI_LAST   = TONE_W'(TONE_HI_HALF - 1);
  localparam logic [TONE_W-1:0] LO_LAST   = TONE_W'(TONE_LO_HALF - 1);
  localparam logic [TONE_W-1:0] TONE_ONE  = TONE_W'(1);
  localparam logic [WARB_W-1:0] WARB_LAST = WARB_W'(WARBLE_COUNT - 1);
  localparam logic [WARB_W-1:0] WARB_ONE  = WARB_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SOUNDING = 2'd1,
    ST_MUTED    = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic [SEC_W-1:0]    sec_cnt_r;
  logic [TONE_W-1:0]   tone_cnt_r;
  logic [WARB_W-1:0]   warble_cnt_r;
  logic                tone_hi_r;
  logic                speaker_r;
  logic                status_led_r;
  logic                siren_active_r;
  logic                siren_lamp_r;
  logic                timed_out_r;

  logic                tick_wrap_s;
  logic                timeout_s;
  logic                tone_last_s;
  logic                warble_last_s;
  logic                keep_sounding_s;
  logic                siren_active_s;
  logic                siren_lamp_s;
  logic                timed_out_s;

  // Terminal-count decodes for the second timer and the tone/warble dividers.
  always_comb begin
    tick_wrap_s   = (tick_cnt_r == TICK_LAST);
    timeout_s     = tick_wrap_s && (sec_cnt_r == SEC_LAST);
    warble_last_s = (warble_cnt_r == WARB_LAST);
    if (tone_hi_r) begin
      tone_last_s = (tone_cnt_r == HI_LAST);
    end else begin
      tone_last_s = (tone_cnt_r == LO_LAST);
    end
  end

  // State register.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a released siren takes priority over the timeout.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.siren) next_state_s = ST_SOUNDING;
        else           next_state_s = ST_IDLE;
      end
      ST_SOUNDING: begin
        if (!bus.siren)    next_state_s = ST_IDLE;
        else if (timeout_s) next_state_s = ST_MUTED;
        else               next_state_s = ST_SOUNDING;
      end
      ST_MUTED: begin
        if (bus.siren) next_state_s = ST_MUTED;
        else           next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode of the next state, so flags change on the same edge as the state.
  always_comb begin
    siren_active_s  = 1'b0;
    siren_lamp_s    = 1'b0;
    timed_out_s     = 1'b0;
    keep_sounding_s = (state_r == ST_SOUNDING) && (next_state_s == ST_SOUNDING);
    case (next_state_s)
      ST_SOUNDING: begin
        siren_active_s = 1'b1;
        siren_lamp_s   = 1'b1;
      end
      ST_MUTED: begin
        siren_lamp_s = 1'b1;
        timed_out_s  = 1'b1;
      end
      default: begin
        siren_active_s = 1'b0;
        siren_lamp_s   = 1'b0;
        timed_out_s    = 1'b0;
      end
    endcase
  end

  // Register the status LED and the state-derived flags.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      status_led_r   <= 1'b0;
      siren_active_r <= 1'b0;
      siren_lamp_r   <= 1'b0;
      timed_out_r    <= 1'b0;
    end else begin
      status_led_r   <= bus.statusIndicator;
      siren_active_r <= siren_active_s;
      siren_lamp_r   <= siren_lamp_s;
      timed_out_r    <= timed_out_s;
    end
  end

  // Timers and warbling tone; everything is cleared whenever we are not
  // staying in SOUNDING, which also gives a clean start on entry.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      tick_cnt_r   <= '0;
      sec_cnt_r    <= '0;
      tone_cnt_r   <= '0;
      warble_cnt_r <= '0;
      tone_hi_r    <= 1'b1;
      speaker_r    <= 1'b0;
    end else if (!keep_sounding_s) begin
      tick_cnt_r   <= '0;
      sec_cnt_r    <= '0;
      tone_cnt_r   <= '0;
      warble_cnt_r <= '0;
      tone_hi_r    <= 1'b1;
      speaker_r    <= 1'b0;
    end else begin
      if (tick_wrap_s) begin
        tick_cnt_r <= '0;
        sec_cnt_r  <= sec_cnt_r + SEC_ONE;
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_ONE;
      end

      if (warble_last_s) begin
        warble_cnt_r <= '0;
        tone_hi_r    <= ~tone_hi_r;
        tone_cnt_r   <= '0;
      end else begin
        warble_cnt_r <= warble_cnt_r + WARB_ONE;
        if (tone_last_s) tone_cnt_r <= '0;
        else             tone_cnt_r <= tone_cnt_r + TONE_ONE;
      end

      if (tone_last_s) speaker_r <= ~speaker_r;
      else             speaker_r <= speaker_r;
    end
  end

  assign bus.speaker     = speaker_r;
  assign bus.statusLed   = status_led_r;
  assign bus.sirenLamp   = siren_lamp_r;
  assign bus.sirenActive = siren_active_r;
  assign bus.timedOut    = timed_out_r;

endmodule
